// File: rtl/alu_ctrl_pkg.sv
// Shared opcode encoding, controller states and flag positions for alu/alu_ctrl.
package alu_ctrl_pkg;
    localparam int ALU_OP_W = 4;

    typedef logic [ALU_OP_W-1:0] alu_op_t;

    localparam alu_op_t OP_LL  = 4'd0;
    localparam alu_op_t OP_LR  = 4'd1;
    localparam alu_op_t OP_AL  = 4'd2;
    localparam alu_op_t OP_AR  = 4'd3;
    localparam alu_op_t OP_NOT = 4'd4;
    localparam alu_op_t OP_AND = 4'd5;
    localparam alu_op_t OP_OR  = 4'd6;
    localparam alu_op_t OP_XOR = 4'd7;
    localparam alu_op_t OP_ADD = 4'd8;
    localparam alu_op_t OP_SUB = 4'd9;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} alu_ctrl_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Encodings 10..15 are unused.
    function automatic logic is_legal_op(input alu_op_t op);
        return op <= OP_SUB;
    endfunction
endpackage

// File: rtl/alu_ctrl_if.sv
// Command and response valid/ready bundle between an initiator and alu_ctrl.
interface alu_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int OP_W  = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [OP_W-1:0]  cmd_op;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic             cmd_use_carry;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_y;
    logic [3:0]       rsp_flags;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_carry, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_y, rsp_flags, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_carry, rsp_ready,
        output cmd_ready, rsp_valid, rsp_y, rsp_flags, rsp_err
    );
endinterface

// File: rtl/alu.sv
// Combinational ALU: shifts, logic ops, ADD/SUB with carry-in (borrow-in for SUB).
module alu
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  alu_op_t          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);
    localparam int M = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // For SUB the top bit of diff is the borrow-out, so C chains as a borrow.
    assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

    always_comb begin
        y        = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_LL, OP_AL: y = a << b;
            OP_LR:        y = a >> b;
            OP_AR:        y = $signed(a) >>> b;
            OP_NOT:       y = ~a;
            OP_AND:       y = a & b;
            OP_OR:        y = a | b;
            OP_XOR:       y = a ^ b;
            OP_ADD: begin
                y        = sum[M:0];
                cout     = sum[WIDTH];
                overflow = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                y        = diff[M:0];
                cout     = diff[WIDTH];
                overflow = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            default: ;
        endcase
    end

    assign negative = y[M];
    assign zero     = (y == '0);
endmodule

// File: rtl/alu_ctrl.sv
// Sequential command front-end for alu with NZCV status register.
// Optional ALU_CTRL_STICKY_OVF_EN adds a sticky overflow output.
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int OP_W  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_ctrl_if.slave  bus,
    input  logic       flags_clr,
    output logic [3:0] flags_q
`ifdef ALU_CTRL_STICKY_OVF_EN
    ,
    output logic       ovf_sticky
`endif
);
    alu_ctrl_state_t  state;
    logic [OP_W-1:0]  op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;

    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;
    logic             neg;
    logic             zero;
    logic [3:0]       f;
    logic             legal;

    assign f     = {neg, zero, cout, ovf};
    assign legal = is_legal_op(op_q);

    alu #(.WIDTH(WIDTH)) u_alu (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .cin      (cin_q),
        .y        (y),
        .cout     (cout),
        .overflow (ovf),
        .negative (neg),
        .zero     (zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_y     <= '0;
            bus.rsp_flags <= '0;
            bus.rsp_err   <= 1'b0;
            flags_q       <= '0;
            op_q          <= '0;
            a_q           <= '0;
            b_q           <= '0;
            cin_q         <= 1'b0;
`ifdef ALU_CTRL_STICKY_OVF_EN
            ovf_sticky    <= 1'b0;
`endif
        end else begin
            // A clear is overridden below by a same-cycle EXEC capture.
            if (flags_clr) begin
                flags_q <= '0;
`ifdef ALU_CTRL_STICKY_OVF_EN
                ovf_sticky <= 1'b0;
`endif
            end
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        op_q          <= bus.cmd_op;
                        a_q           <= bus.cmd_a;
                        b_q           <= bus.cmd_b;
                        cin_q         <= bus.cmd_use_carry & flags_q[FLAG_C];
                        state         <= EXEC;
                        bus.cmd_ready <= 1'b0;
                    end
                end
                EXEC: begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                    if (legal) begin
                        bus.rsp_y     <= y;
                        bus.rsp_flags <= f;
                        bus.rsp_err   <= 1'b0;
                        flags_q       <= f;
`ifdef ALU_CTRL_STICKY_OVF_EN
                        if (f[FLAG_V]) ovf_sticky <= 1'b1;
`endif
                    end else begin
                        bus.rsp_y     <= '0;
                        bus.rsp_flags <= '0;
                        bus.rsp_err   <= 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_ctrl.sv
// Directed-vector bench for alu_ctrl with an arithmetic reference model and scoreboard.
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    typedef struct {
        logic [3:0] y;
        logic [3:0] f;
        logic       err;
        logic [3:0] fq;
        int         acc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       flags_clr;
    logic [3:0] flags_q;
`ifdef ALU_CTRL_STICKY_OVF_EN
    logic       ovf_sticky;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q[$];
    logic [3:0] flags_m = 4'h0;
    logic       sticky_m = 1'b0;
    bit   popped = 0;
    bit   seen = 0;

    alu_ctrl_if #(.WIDTH(4), .OP_W(4)) bus ();

    alu_ctrl #(.WIDTH(4), .OP_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .flags_clr (flags_clr),
        .flags_q   (flags_q)
`ifdef ALU_CTRL_STICKY_OVF_EN
        ,
        .ovf_sticky(ovf_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference arithmetic on plain integers, signed view for V.
    function automatic void model(input alu_op_t op, input logic [3:0] a,
                                  input logic [3:0] b, input logic cin,
                                  output logic [3:0] y, output logic [3:0] f,
                                  output logic err);
        int ia, ib, sa, sb, r, sr, ic;
        logic c, v;
        ia = int'(a);
        ib = int'(b);
        ic = cin ? 1 : 0;
        sa = (ia > 7) ? ia - 16 : ia;
        sb = (ib > 7) ? ib - 16 : ib;
        c = 1'b0;
        v = 1'b0;
        err = 1'b0;
        r = 0;
        case (op)
            OP_LL, OP_AL: r = ia << ib;
            OP_LR:  r = ia >> ib;
            OP_AR:  r = sa >>> ib;
            OP_NOT: r = ~ia;
            OP_AND: r = ia & ib;
            OP_OR:  r = ia | ib;
            OP_XOR: r = ia ^ ib;
            OP_ADD: begin
                r = ia + ib + ic;
                c = (r > 15);
                sr = sa + sb + ic;
                v = (sr > 7) || (sr < -8);
            end
            OP_SUB: begin
                r = ia - ib - ic;
                c = (r < 0);
                sr = sa - sb - ic;
                v = (sr > 7) || (sr < -8);
            end
            default: err = 1'b1;
        endcase
        y = err ? 4'h0 : r[3:0];
        f = err ? 4'h0 : {y[3], (y == 4'h0), c, v};
    endfunction

    // Compare process: every cycle, against the scoreboard front.
    always @(negedge clk) begin
        if (rst_n) begin
            if (popped) begin
                chk("post_pop_rsp_valid", bus.rsp_valid, 0);
                chk("post_pop_cmd_ready", bus.cmd_ready, 1);
            end
            popped = 0;
            if (bus.rsp_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_rsp", bus.rsp_valid, 0);
                end else begin
                    if (!seen) begin
                        chk("latency", cyc, q[0].acc + 1);
                        seen = 1;
                    end
                    chk("rsp_y", bus.rsp_y, q[0].y);
                    chk("rsp_flags", bus.rsp_flags, q[0].f);
                    chk("rsp_err", bus.rsp_err, q[0].err);
                    chk("flags_q_resp", flags_q, q[0].fq);
                    chk("cmd_ready_resp", bus.cmd_ready, 0);
                    if (bus.rsp_ready) begin
                        void'(q.pop_front());
                        popped = 1;
                        seen = 0;
                    end
                end
            end else if (bus.cmd_ready) begin
                chk("flags_q_idle", flags_q, flags_m);
`ifdef ALU_CTRL_STICKY_OVF_EN
                chk("ovf_sticky_idle", ovf_sticky, sticky_m);
`endif
            end
        end
    end

    task automatic send(input alu_op_t op, input logic [3:0] a,
                        input logic [3:0] b, input logic uc);
        int n;
        logic [3:0] y, f;
        logic e;
        exp_t x;
        n = 0;
        @(negedge clk);
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = op;
        bus.cmd_a = a;
        bus.cmd_b = b;
        bus.cmd_use_carry = uc;
        model(op, a, b, uc & flags_m[FLAG_C], y, f, e);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        if (!e) flags_m = f;
        if (!e && f[FLAG_V]) sticky_m = 1'b1;
        x.y = y;
        x.f = f;
        x.err = e;
        x.fq = flags_m;
        x.acc = cyc;
        q.push_back(x);
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_timeout", q.size(), 0);
    endtask

    task automatic clr();
        @(posedge clk);
        #1 flags_clr = 1'b1;
        @(posedge clk);
        #1 flags_clr = 1'b0;
        flags_m = 4'h0;
        sticky_m = 1'b0;
    endtask

    task automatic run(input alu_op_t op, input logic [3:0] a,
                       input logic [3:0] b, input logic uc);
        send(op, a, b, uc);
        wait_rsp();
    endtask

    initial begin
        rst_n = 1'b0;
        flags_clr = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = '0;
        bus.cmd_a = '0;
        bus.cmd_b = '0;
        bus.cmd_use_carry = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_y", bus.rsp_y, 0);
        chk("rst_rsp_flags", bus.rsp_flags, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_flags_q", flags_q, 0);

        run(OP_ADD, 4'b0100, 4'b0110, 1'b0);
        chk("add_y", bus.rsp_y, 4'b1010);
        chk("add_flags", bus.rsp_flags, 4'b1001);
        chk("add_flags_q", flags_q, 4'b1001);
`ifdef ALU_CTRL_STICKY_OVF_EN
        chk("sticky_set", ovf_sticky, 1);
`endif
        clr();
        @(negedge clk);
        chk("clr_flags_q", flags_q, 0);
`ifdef ALU_CTRL_STICKY_OVF_EN
        chk("sticky_clr", ovf_sticky, 0);
`endif

        run(OP_ADD, 4'b1111, 4'b0001, 1'b0);
        chk("carry_y", bus.rsp_y, 4'b0000);
        chk("carry_flags", bus.rsp_flags, 4'b0110);
        run(OP_ADD, 4'b0000, 4'b0000, 1'b1);
        chk("chain_y", bus.rsp_y, 4'b0001);

        run(OP_ADD, 4'b1111, 4'b0001, 1'b0);
        clr();
        run(OP_ADD, 4'b0000, 4'b0000, 1'b1);
        chk("chain_after_clr_y", bus.rsp_y, 4'b0000);

        run(OP_ADD, 4'b1111, 4'b0001, 1'b0);
        run(OP_SUB, 4'b1000, 4'b0011, 1'b1);
        chk("borrow_y", bus.rsp_y, 4'b0100);
        chk("borrow_flags", bus.rsp_flags, 4'b0001);

        run(OP_LL, 4'b0011, 4'd2, 1'b1);
        run(OP_LR, 4'b1100, 4'd3, 1'b0);
        run(OP_AL, 4'b0101, 4'd1, 1'b0);
        run(OP_NOT, 4'b0101, 4'b0000, 1'b0);
        run(OP_AND, 4'b1100, 4'b1010, 1'b0);
        run(OP_OR, 4'b1100, 4'b1010, 1'b0);
        run(OP_XOR, 4'b1100, 4'b1100, 1'b0);
        run(OP_SUB, 4'b0011, 4'b0101, 1'b0);
        run(OP_SUB, 4'b0000, 4'b0000, 1'b1);
        run(OP_ADD, 4'b0111, 4'b0001, 1'b0);

        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        send(OP_AR, 4'b1001, 4'b0001, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", bus.rsp_valid, 1);
            chk("bp_rsp_y", bus.rsp_y, 4'b1100);
            chk("bp_cmd_ready", bus.cmd_ready, 0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        wait_rsp();
        @(negedge clk);
        chk("bp_release_ready", bus.cmd_ready, 1);

        run(OP_XOR, 4'b1100, 4'b1111, 1'b0);
        run(4'hC, 4'b0101, 4'b0011, 1'b0);
        chk("illegal_err", bus.rsp_err, 1);
        chk("illegal_y", bus.rsp_y, 0);
        chk("illegal_flags", bus.rsp_flags, 0);
        chk("illegal_flags_q", flags_q, 4'b0000);
        run(OP_AR, 4'b1001, 4'b0001, 1'b0);
        run(4'hF, 4'b1111, 4'b1111, 1'b1);
        chk("illegal2_flags_q", flags_q, 4'b1000);

        send(OP_ADD, 4'b0111, 4'b0001, 1'b0);
        rst_n = 1'b0;
        q.delete();
        seen = 0;
        flags_m = 4'h0;
        sticky_m = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_rsp_valid", bus.rsp_valid, 0);
        chk("midrst_flags_q", flags_q, 0);
        chk("midrst_cmd_ready", bus.cmd_ready, 1);
        repeat (4) begin
            @(negedge clk);
            chk("midrst_no_rsp", bus.rsp_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got %0d expected finish", cyc);
        $fatal(1);
    end
endmodule
